// File: rtl/instruction_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_queue_if
// Description : Bundle of start/boot, instruction-memory, redirect and
//               instruction-delivery signals of the fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_queue_if #(
  parameter int WORD_RANGE = 8,
  parameter int INST_RANGE = 12
);
  logic [WORD_RANGE-1:0] init_PC;
  logic                  start;
  logic                  imem_req;
  logic [WORD_RANGE-1:0] imem_addr;
  logic [INST_RANGE-1:0] imem_rdata;
  logic                  redirect;
  logic [WORD_RANGE-1:0] redirect_pc;
  logic [INST_RANGE-1:0] inst_out;
  logic [WORD_RANGE-1:0] inst_pc;
  logic                  inst_valid;
  logic                  inst_ready;

  // Fetch-queue side
  modport master (
    input  init_PC, start, imem_rdata, redirect, redirect_pc, inst_ready,
    output imem_req, imem_addr, inst_out, inst_pc, inst_valid
  );

  // Environment side (memory, control unit, consumer)
  modport slave (
    output init_PC, start, imem_rdata, redirect, redirect_pc, inst_ready,
    input  imem_req, imem_addr, inst_out, inst_pc, inst_valid
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_queue
// Description : Sequential instruction fetcher with a small prefetch queue,
//               valid/ready delivery and branch/jump redirect with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_queue #(
  parameter int WORD_RANGE  = 8,
  parameter int INST_RANGE  = 12,
  parameter int QUEUE_DEPTH = 4
) (
  input wire logic                   clk,
  input wire logic                   rst_n,
  instruction_fetch_queue_if.master  bus
);

  localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(QUEUE_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WORD_RANGE-1:0] r_pc;
  logic [WORD_RANGE-1:0] w_pc_next;
  logic [WORD_RANGE-1:0] r_req_pc;
  logic                  r_inflight;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_CNT_W-1:0]    w_occupancy;
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [INST_RANGE-1:0] r_q_inst [QUEUE_DEPTH];
  logic [WORD_RANGE-1:0] r_q_pc   [QUEUE_DEPTH];
  logic                  w_req;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_pop;

  // Slots already committed: queued entries plus the response still on its way
  assign w_occupancy = r_count + {{(c_CNT_W-1){1'b0}}, r_inflight};

  // A response is dropped when a redirect lands in the cycle it arrives
  assign w_push = r_inflight && !w_flush;
  assign w_pop  = (r_count != '0) && bus.inst_ready;

  // Next-state, fetch issue and next-PC decisions
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_flush      = 1'b0;
    w_pc_next    = r_pc;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_RUN;
          w_pc_next    = bus.init_PC;
        end
      end
      ST_RUN: begin
        if (bus.redirect) begin
          w_flush   = 1'b1;
          w_pc_next = bus.redirect_pc;
        end else if (w_occupancy < c_DEPTH) begin
          w_req     = 1'b1;
          w_pc_next = r_pc + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; only reset brings the machine back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Program counter and outstanding-request tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_inflight <= w_req;
      if (w_req) r_req_pc <= r_pc;
    end
  end

  // Queue pointers and occupancy; a flush wins over a coincident push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: captured instruction paired with the address it came from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_q_inst[r_tail] <= bus.imem_rdata;
      r_q_pc[r_tail]   <= r_req_pc;
    end
  end

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.inst_out   = r_q_inst[r_head];
  assign bus.inst_pc    = r_q_pc[r_head];
  assign bus.inst_valid = (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_queue
// Description : Self-checking bench for instruction_fetch_queue with a
//               behavioural model of the delivered instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_queue;

  logic clk = 1'b0;
  logic rst_n;

  instruction_fetch_queue_if #(.WORD_RANGE(8), .INST_RANGE(12)) bus ();

  instruction_fetch_queue #(
    .WORD_RANGE (8),
    .INST_RANGE (12),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a is {4'ha, a}, one cycle latency;
  // unrequested cycles return noise so spurious captures are visible
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= {4'ha, bus.imem_addr};
    else              bus.imem_rdata <= 12'($urandom);
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_run;
  logic [7:0]  m_pc;      // next address the consumer must receive
  logic [7:0]  m_fetch;   // next address the fetcher must request
  int          m_out;     // requested but not yet delivered (since flush)
  int          m_nreq;
  int          n_deliv;

  // Values sampled during the last step
  int unsigned s_valid, s_req, s_addr, s_pop, s_pop_pc;
  int unsigned wrap_pc [4];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after a falling edge, sample, update model
  task automatic step(input logic rdy, input logic st, input logic rd, input logic [7:0] rpc);
    bus.inst_ready  = rdy;
    bus.start       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    #2;
    s_valid  = 32'(bus.inst_valid);
    s_req    = 32'(bus.imem_req);
    s_addr   = 32'(bus.imem_addr);
    s_pop    = 0;
    s_pop_pc = 32'hFFFF;
    if (!m_run) begin
      check_eq("idle_req", s_req, 0);
      check_eq("idle_valid", s_valid, 0);
    end else begin
      if (rd) check_eq("redir_req", s_req, 0);
      else    check_eq("req_gate", s_req, (m_out < 4) ? 1 : 0);
      if (s_req != 0) begin
        check_eq("fetch_addr", s_addr, 32'(m_fetch));
        m_fetch = m_fetch + 8'd1;
        m_nreq++;
        m_out++;
      end
      if (s_valid != 0 && rdy) begin
        check_eq("deliv_pc", 32'(bus.inst_pc), 32'(m_pc));
        check_eq("deliv_inst", 32'(bus.inst_out), 32'({4'ha, m_pc}));
        s_pop    = 1;
        s_pop_pc = 32'(bus.inst_pc);
        m_pc     = m_pc + 8'd1;
        m_out--;
        n_deliv++;
      end
      if (rd) begin
        m_pc    = rpc;
        m_fetch = rpc;
        m_out   = 0;
      end
    end
    if (!m_run && st) begin
      m_run   = 1'b1;
      m_pc    = bus.init_PC;
      m_fetch = bus.init_PC;
      m_out   = 0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req", 32'(bus.imem_req), 0);
    check_eq("rst_addr", 32'(bus.imem_addr), 0);
    check_eq("rst_valid", 32'(bus.inst_valid), 0);
    check_eq("rst_inst", 32'(bus.inst_out), 0);
    check_eq("rst_pc", 32'(bus.inst_pc), 0);
  endtask

  // Asynchronous reset pulse between clock edges, then realign to a falling edge
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    m_run = 1'b0;
    m_out = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.init_PC     = '0;
    bus.start       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    m_run = 1'b0; m_pc = '0; m_fetch = '0; m_out = 0; m_nreq = 0; n_deliv = 0;
    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Start latency and sustained throughput
    bus.init_PC = 8'h10;
    step(1, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check_eq("start_req", s_req, 1);
    check_eq("start_addr", s_addr, 32'h10);
    check_eq("lat_v1", s_valid, 0);
    step(1, 0, 0, 8'h00);
    check_eq("lat_v2", s_valid, 0);
    step(1, 0, 0, 8'h00);
    check_eq("lat_v3", s_valid, 1);
    check_eq("first_pc", s_pop_pc, 32'h10);
    n_deliv = 0;
    repeat (20) step(1, 0, 0, 8'h00);
    check_eq("throughput", 32'(n_deliv), 20);

    // Reset mid-stream with a response in flight; afterwards stay idle
    check_eq("pre_rst_req", s_req, 1);
    pulse_reset();
    for (int i = 0; i < 6; i++) step(1'($urandom), 1'b0, 1'($urandom), 8'($urandom));

    // Back-pressure
    bus.init_PC = 8'h10;
    step(0, 1, 0, 8'h00);
    m_nreq = 0;
    repeat (10) step(0, 0, 0, 8'h00);
    check_eq("bp_reqs", 32'(m_nreq), 4);
    check_eq("bp_stall", s_req, 0);
    step(1, 0, 0, 8'h00);
    check_eq("bp_pop_pc", s_pop_pc, 32'h10);
    check_eq("bp_pop_req", s_req, 0);
    step(0, 0, 0, 8'h00);
    check_eq("bp_resume_req", s_req, 1);
    check_eq("bp_resume_addr", s_addr, 32'h14);

    // Redirect with the queue committed full and a response in flight
    step(0, 0, 1, 8'h40);
    check_eq("rd_req0", s_req, 0);
    step(0, 0, 0, 8'h00);
    check_eq("rd_req1", s_req, 1);
    check_eq("rd_addr1", s_addr, 32'h40);
    step(1, 0, 0, 8'h00);
    check_eq("rd_v_early", s_valid, 0);
    step(1, 0, 0, 8'h00);
    check_eq("rd_first_pc", s_pop_pc, 32'h40);

    // Redirect coincident with a pop handshake
    repeat (3) step(1, 0, 0, 8'h00);
    n_deliv = 0;
    step(1, 0, 1, 8'h80);
    check_eq("coinc_pop", 32'(n_deliv), 1);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check_eq("coinc_next_pc", s_pop_pc, 32'h80);

    // Address wrap
    pulse_reset();
    bus.init_PC = 8'hFE;
    step(1, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00);
      wrap_pc[i] = s_pop_pc;
    end
    check_eq("wrap0", wrap_pc[0], 32'hFE);
    check_eq("wrap1", wrap_pc[1], 32'hFF);
    check_eq("wrap2", wrap_pc[2], 32'h00);
    check_eq("wrap3", wrap_pc[3], 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
